spi_slave_port: RTL and testbench



---
 rtl/spi_slave_port.sv | 190 +++++++++++++++++++
 tb/tb_spi_slave_port.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_port.sv
// spi_slave_port: oversampled SPI responder for all four clock modes.
// Deserialises MOSI into words and serialises a one-deep tx holding register.
module spi_slave_port #(
  parameter int unsigned PHASE     = 0,
  parameter int unsigned ACTIVE    = 0,
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             spi_sck,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [DSIZE-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [DSIZE-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             cs_active
);

  localparam int unsigned CW = $clog2(DSIZE);
  localparam logic [CW-1:0] LAST = CW'(DSIZE - 1);
  localparam logic SCK_IDLE = (ACTIVE != 0);

  typedef enum logic {
    S_IDLE,
    S_SEL
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_mosi_s1, r_mosi_s2;

  logic [CW-1:0]    r_cnt;
  logic [DSIZE-1:0] r_rx_sr;
  logic [DSIZE-1:0] r_tx_sr;
  logic [DSIZE-1:0] r_hold;
  logic             r_hold_full;
  logic [DSIZE-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_underrun;

  logic w_sck_rise, w_sck_fall;
  logic w_lead, w_trail;
  logic w_sample, w_shift;
  logic w_cs_fall, w_cs_rise;
  logic w_enter, w_leave;
  logic w_edges_ok;
  logic w_do_sample, w_do_shift;
  logic w_load, w_hs;
  logic [DSIZE-1:0] w_rx_word;
  logic [DSIZE-1:0] w_tx_next;

  // Two-flop synchronisers plus a history flop for edge detection.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_s1  <= SCK_IDLE;
      r_sck_s2  <= SCK_IDLE;
      r_sck_s3  <= SCK_IDLE;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_sck_s1  <= spi_sck;
      r_sck_s2  <= r_sck_s1;
      r_sck_s3  <= r_sck_s2;
      r_cs_s1   <= spi_cs_n;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= spi_mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_sck_rise = r_sck_s2 & ~r_sck_s3;
  assign w_sck_fall = ~r_sck_s2 & r_sck_s3;
  assign w_lead     = (ACTIVE != 0) ? w_sck_fall : w_sck_rise;
  assign w_trail    = (ACTIVE != 0) ? w_sck_rise : w_sck_fall;
  assign w_sample   = (PHASE == 0) ? w_lead : w_trail;
  assign w_shift    = (PHASE == 0) ? w_trail : w_lead;
  assign w_cs_fall  = ~r_cs_s2 & r_cs_s3;
  assign w_cs_rise  = r_cs_s2 & ~r_cs_s3;

  // Select state machine: next state and entry/exit strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_leave     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = S_SEL;
          w_enter     = 1'b1;
        end
      end
      S_SEL: begin
        if (w_cs_rise) begin
          w_state_nxt = S_IDLE;
          w_leave     = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_edges_ok  = (r_state == S_SEL) && !w_cs_rise;
  assign w_do_sample = w_edges_ok && w_sample;
  assign w_do_shift  = w_edges_ok && w_shift;
  assign w_load      = ((PHASE == 0) && w_enter) ||
                       (w_do_shift && (r_cnt == '0));
  assign w_hs        = tx_valid && !r_hold_full;

  assign w_rx_word = (MSB_FIRST != 0) ?
                     {r_rx_sr[DSIZE-2:0], r_mosi_s2} :
                     {r_mosi_s2, r_rx_sr[DSIZE-1:1]};
  assign w_tx_next = (MSB_FIRST != 0) ?
                     {r_tx_sr[DSIZE-2:0], 1'b0} :
                     {1'b0, r_tx_sr[DSIZE-1:1]};

  // Receive path: bit counter, shift register and word strobe.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rx_sr    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_enter || w_leave) begin
        r_cnt <= '0;
      end else if (w_do_sample) begin
        r_rx_sr <= w_rx_word;
        if (r_cnt == LAST) begin
          r_cnt      <= '0;
          r_rx_data  <= w_rx_word;
          r_rx_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  // Transmit path: holding register, load/underrun and shift.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_sr     <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_load) begin
        r_tx_sr     <= r_hold_full ? r_hold : '1;
        r_underrun  <= !r_hold_full;
        r_hold_full <= 1'b0;
      end else if (w_do_shift) begin
        r_tx_sr <= w_tx_next;
      end
      if (w_hs) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign spi_miso    = (MSB_FIRST != 0) ? r_tx_sr[DSIZE-1] : r_tx_sr[0];
  assign cs_active   = (r_state == S_SEL);
  assign spi_miso_oe = cs_active;
  assign tx_ready    = !r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: directed SPI master stimulus with an rx scoreboard.
// Instances 0..3 cover the four clock modes; instance 4 is 16-bit LSB first.
module tb_spi_slave_port;

  localparam int HALF = 6;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] sck;
  logic [4:0] cs_n;
  logic [4:0] mosi;
  logic [4:0] txv;
  wire  [4:0] miso;
  wire  [4:0] oe;
  wire  [4:0] txr;
  wire  [4:0] rxv;
  wire  [4:0] und;
  wire  [4:0] csa;
  logic [7:0] txd8 [4];
  logic [7:0] rxd8 [4];
  logic [15:0] txd16;
  logic [15:0] rxd16;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int und_cnt [5];
  int und_snap [5];
  int rxv_cnt [5];

  logic [31:0] r0, r1, r2;

  for (genvar g = 0; g < 4; g++) begin : g_m
    spi_slave_port #(
      .PHASE(g / 2), .ACTIVE(g % 2), .DSIZE(8), .MSB_FIRST(1)
    ) u_dut (
      .clock(clock), .rst_n(rst_n),
      .spi_sck(sck[g]), .spi_cs_n(cs_n[g]), .spi_mosi(mosi[g]),
      .spi_miso(miso[g]), .spi_miso_oe(oe[g]),
      .tx_data(txd8[g]), .tx_valid(txv[g]), .tx_ready(txr[g]),
      .rx_data(rxd8[g]), .rx_valid(rxv[g]),
      .tx_underrun(und[g]), .cs_active(csa[g])
    );
  end

  spi_slave_port #(
    .PHASE(0), .ACTIVE(0), .DSIZE(16), .MSB_FIRST(0)
  ) u_lsb16 (
    .clock(clock), .rst_n(rst_n),
    .spi_sck(sck[4]), .spi_cs_n(cs_n[4]), .spi_mosi(mosi[4]),
    .spi_miso(miso[4]), .spi_miso_oe(oe[4]),
    .tx_data(txd16), .tx_valid(txv[4]), .tx_ready(txr[4]),
    .rx_data(rxd16), .rx_valid(rxv[4]),
    .tx_underrun(und[4]), .cs_active(csa[4])
  );

  initial forever #5 clock = ~clock;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops an expected word on every rx_valid.
  initial forever begin
    @(negedge clock);
    if (rst_n) begin
      for (int i = 0; i < 5; i++) begin
        if (und[i]) und_cnt[i]++;
        if (rxv[i]) begin
          logic [31:0] got;
          exp_t e;
          got = (i == 4) ? {16'h0, rxd16} : {24'h0, rxd8[i]};
          rxv_cnt[i]++;
          und_snap[i] = und_cnt[i];
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected inst %0d: got %h expected none", i, got);
          end else begin
            e = exp_q.pop_front();
            if (e.idx != i || e.data !== got) begin
              n_fail++;
              $display("FAIL rx_data inst %0d: got %h expected inst %0d %h",
                       i, got, e.idx, e.data);
            end
          end
        end
      end
    end
  end

  function automatic bit act_of(int idx);
    return (idx < 4) ? bit'(idx % 2) : 1'b0;
  endfunction

  function automatic bit ph_of(int idx);
    return (idx < 4) ? bit'(idx / 2) : 1'b0;
  endfunction

  task automatic half();
    repeat (HALF) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    sck   = 5'b01010;
    cs_n  = '1;
    mosi  = '0;
    txv   = '0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      und_cnt[i]  = 0;
      und_snap[i] = 0;
      rxv_cnt[i]  = 0;
    end
    @(negedge clock);
  endtask

  task automatic chk_reset(int idx);
    logic [31:0] rd;
    rd = (idx == 4) ? {16'h0, rxd16} : {24'h0, rxd8[idx]};
    chk("rst_miso", miso[idx], 0);
    chk("rst_miso_oe", oe[idx], 0);
    chk("rst_rx_data", rd, 0);
    chk("rst_rx_valid", rxv[idx], 0);
    chk("rst_underrun", und[idx], 0);
    chk("rst_cs_active", csa[idx], 0);
    chk("rst_tx_ready", txr[idx], 1);
  endtask

  task automatic push(int idx, logic [31:0] d);
    int t = 0;
    while (!txr[idx] && t < 3000) begin
      @(negedge clock);
      t++;
    end
    chk("tx_ready_wait", txr[idx], 1);
    if (txr[idx]) begin
      if (idx < 4) txd8[idx] = d[7:0];
      else         txd16 = d[15:0];
      txv[idx] = 1'b1;
      @(negedge clock);
      txv[idx] = 1'b0;
    end
  endtask

  task automatic sel(int idx);
    cs_n[idx] = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic desel(int idx);
    half();
    cs_n[idx] = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic word(int idx, int n, logic [31:0] dout, int nb,
                      output logic [31:0] din);
    bit a;
    bit ph;
    a   = act_of(idx);
    ph  = ph_of(idx);
    din = '0;
    if (nb == n) exp_q.push_back('{idx: idx, data: dout});
    for (int i = 0; i < nb; i++) begin
      int p;
      p = (idx < 4) ? n - 1 - i : i;
      if (!ph) begin
        mosi[idx] = dout[p];
        half();
        din[p] = miso[idx];
        sck[idx] = ~a;
        half();
        sck[idx] = a;
      end else begin
        sck[idx] = ~a;
        mosi[idx] = dout[p];
        half();
        din[p] = miso[idx];
        sck[idx] = a;
        half();
      end
    end
  endtask

  initial begin
    sck  = 5'b01010;
    cs_n = '1;
    mosi = '0;
    txv  = '0;
    txd16 = '0;
    for (int i = 0; i < 4; i++) txd8[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset(0);
    chk_reset(4);

    // Mode 0 basic exchange
    do_reset();
    push(0, 32'h3C);
    sel(0);
    word(0, 8, 32'hA5, 8, r0);
    desel(0);
    chk("m0_miso", r0, 32'h3C);
    chk("m0_rx_pulses", rxv_cnt[0], 1);
    chk("m0_underrun", und_snap[0], 0);

    // All four modes, three back-to-back words
    for (int m = 0; m < 4; m++) begin
      do_reset();
      push(m, 32'h5A);
      sel(m);
      fork
        push(m, 32'hC3);
        begin
          word(m, 8, 32'h01, 8, r0);
          word(m, 8, 32'h80, 8, r1);
          word(m, 8, 32'hFF, 8, r2);
        end
      join
      desel(m);
      chk($sformatf("mode%0d_miso0", m), r0, 32'h5A);
      chk($sformatf("mode%0d_miso1", m), r1, 32'hC3);
      chk($sformatf("mode%0d_miso2", m), r2, 32'hFF);
      chk($sformatf("mode%0d_underrun", m), und_snap[m], 1);
      chk($sformatf("mode%0d_rx_pulses", m), rxv_cnt[m], 3);
    end

    // Abort after 5 bits, then a full word
    do_reset();
    sel(0);
    word(0, 8, 32'h96, 5, r0);
    desel(0);
    chk("abort_no_rx", rxv_cnt[0], 0);
    sel(0);
    word(0, 8, 32'h42, 8, r0);
    desel(0);
    chk("abort_next_rx", rxv_cnt[0], 1);

    // Handshake on the entry load point with holding empty
    do_reset();
    cs_n[0] = 1'b0;
    repeat (2) @(negedge clock);
    txd8[0] = 8'h69;
    txv[0] = 1'b1;
    @(negedge clock);
    txv[0] = 1'b0;
    #1;
    chk("coll_tx_ready", txr[0], 0);
    chk("coll_underrun", und_cnt[0], 1);
    repeat (5) @(negedge clock);
    word(0, 8, 32'h11, 8, r0);
    word(0, 8, 32'h22, 8, r1);
    desel(0);
    chk("coll_miso0", r0, 32'hFF);
    chk("coll_miso1", r1, 32'h69);
    chk("coll_underrun_total", und_snap[0], 1);

    // 16-bit LSB first
    do_reset();
    push(4, 32'hBEEF);
    sel(4);
    word(4, 16, 32'h1234, 16, r0);
    desel(4);
    chk("lsb16_miso", r0, 32'hBEEF);
    chk("lsb16_rx_pulses", rxv_cnt[4], 1);

    // Reset mid-transfer, then recovery
    do_reset();
    push(0, 32'hA1);
    sel(0);
    word(0, 8, 32'h5C, 3, r0);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    @(negedge clock);
    rst_n = 1'b1;
    cs_n[0] = 1'b1;
    repeat (8) @(negedge clock);
    push(0, 32'h7E);
    sel(0);
    word(0, 8, 32'hC9, 8, r0);
    desel(0);
    chk("rstmid_miso", r0, 32'h7E);
    chk("rstmid_rx_pulses", rxv_cnt[0], 1);

    chk("rx_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
